// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: emits the kept lanes of each wide beat one at a time, lowest index first.
// Optional STREAM_DOWNSIZER_PREFETCH_EN lets the final lane handshake overlap the next wide beat's load.
//
// state | meaning
// IDLE  | no beat held, ready to accept a wide beat
// SEND  | presenting lanes of the held beat, lowest remaining index first
module stream_downsizer #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int IDX_W = $clog2(T_DATA_RATIO);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [T_DATA_WIDTH-1:0] lane_buf [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] rem_q, rem_d;
  logic                    last_q;
  logic [IDX_W-1:0]        lane_idx;
  logic                    lane_found;
  logic                    single;
  logic                    load;
  logic                    m_fire;

  always_comb begin
    lane_idx   = '0;
    lane_found = 1'b0;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      if (rem_q[i] && !lane_found) begin
        lane_idx   = IDX_W'(i);
        lane_found = 1'b1;
      end
    end
  end

  assign single = (rem_q != '0) && ((rem_q & (rem_q - T_DATA_RATIO'(1))) == '0);

  // Outputs decode from registers only; nothing combinational from the s_* side.
  assign m_valid_o = (state_q == SEND);
  assign m_data_o  = lane_buf[lane_idx];
  assign m_last_o  = (state_q == SEND) && last_q && single;

`ifdef STREAM_DOWNSIZER_PREFETCH_EN
  assign s_ready_o = !rst && ((state_q == IDLE) || (m_ready_i && single));
`else
  assign s_ready_o = !rst && (state_q == IDLE);
`endif

  assign load   = s_valid_i && s_ready_o;
  assign m_fire = m_valid_o && m_ready_i;

  // A load on the same edge as the final lane wins, so the new beat follows without a bubble.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (m_fire) begin
      rem_d = rem_q & (rem_q - T_DATA_RATIO'(1));
      if (rem_d == '0) state_d = IDLE;
    end
    if (load) begin
      rem_d   = s_keep_i;
      state_d = (s_keep_i != '0) ? SEND : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) lane_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (load) begin
        last_q <= s_last_i;
        for (int i = 0; i < T_DATA_RATIO; i++) lane_buf[i] <= s_data_i[i];
      end
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer (4-bit lanes, ratio 2): queue model plus directed literal checks.
// Honours STREAM_DOWNSIZER_PREFETCH_EN when choosing timing expectations.
module tb_stream_downsizer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_data_i [1:0];
  logic [1:0] s_keep_i;
  logic       s_last_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [3:0] m_data_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int accept_cyc;

`ifdef STREAM_DOWNSIZER_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  stream_downsizer #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_keep_i(s_keep_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: each accepted wide beat becomes its kept lanes in ascending order; last rides on the top kept lane.
  typedef struct packed {logic [3:0] d; logic l;} word_t;
  word_t      exp_q[$];
  logic       hold_v = 1'b0;
  logic [3:0] hold_d;
  logic       hold_l;

  always @(negedge clk) begin
    word_t w;
    int    hi;
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, hold_d);
        chk("hold_last", m_last_o, hold_l);
      end
      if (m_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid actual data=%0h required no output", m_data_o);
        end else if (m_ready_i) begin
          w = exp_q.pop_front();
          chk("model_data", m_data_o, w.d);
          chk("model_last", m_last_o, w.l);
        end
      end
      hold_v = m_valid_o && !m_ready_i;
      hold_d = m_data_o;
      hold_l = m_last_o;
      if (s_valid_i && s_ready_o) begin
        hi = -1;
        for (int i = 0; i < 2; i++) if (s_keep_i[i]) hi = i;
        for (int i = 0; i < 2; i++)
          if (s_keep_i[i]) exp_q.push_back({s_data_i[i], s_last_i && (i == hi)});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge with s_valid_i cleared.
  task automatic send(input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] keep, input logic last);
    bit ok;
    s_data_i[0] = d0;
    s_data_i[1] = d1;
    s_keep_i    = keep;
    s_last_i    = last;
    s_valid_i   = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (s_ready_o) begin
        ok = 1'b1;
        accept_cyc = cyc;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual s_ready_o=0 required 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [3:0] d, input logic l);
    @(negedge clk);
    chk({name, "_valid"}, m_valid_o, v);
    if (v) begin
      chk({name, "_data"}, m_data_o, d);
      chk({name, "_last"}, m_last_o, l);
    end
  endtask

  initial begin
    int a1, a2, a4;
    rst         = 1'b1;
    s_valid_i   = 1'b0;
    s_keep_i    = 2'b00;
    s_last_i    = 1'b0;
    s_data_i[0] = 4'h0;
    s_data_i[1] = 4'h0;
    m_ready_i   = 1'b1;

    @(negedge clk);
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_m_last", m_last_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready_o, 1);
    @(posedge clk); #1;

    // Full beat
    send(4'hA, 4'hB, 2'b11, 1'b1);
    expect_out("full0", 1'b1, 4'hA, 1'b0);
    chk("full0_s_ready", s_ready_o, 0);
    expect_out("full1", 1'b1, 4'hB, 1'b1);
    chk("full1_s_ready", s_ready_o, PREFETCH);
    expect_out("full_end", 1'b0, 4'h0, 1'b0);
    chk("full_end_s_ready", s_ready_o, 1);
    @(posedge clk); #1;

    // Partial beat: lane 0 skipped
    send(4'h3, 4'h5, 2'b10, 1'b1);
    expect_out("part0", 1'b1, 4'h5, 1'b1);
    expect_out("part_end", 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;

    // Backpressure
    m_ready_i = 1'b0;
    send(4'hA, 4'hB, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_out("bp_hold", 1'b1, 4'hA, 1'b0);
      chk("bp_s_ready", s_ready_o, 0);
    end
    @(posedge clk); #1;
    m_ready_i = 1'b1;
    expect_out("bp0", 1'b1, 4'hA, 1'b0);
    expect_out("bp1", 1'b1, 4'hB, 1'b1);
    expect_out("bp_end", 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;

    // Zero keep, then a normal beat
    send(4'h1, 4'h2, 2'b00, 1'b1);
    expect_out("zk", 1'b0, 4'h0, 1'b0);
    chk("zk_s_ready", s_ready_o, 1);
    @(posedge clk); #1;
    send(4'h4, 4'h6, 2'b01, 1'b0);
    expect_out("zk_next", 1'b1, 4'h4, 1'b0);
    expect_out("zk_next_end", 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;

    // Streaming: beat-to-beat spacing reveals the bubble (or its absence)
    send(4'h1, 4'h2, 2'b11, 1'b0); a1 = accept_cyc;
    send(4'h3, 4'h4, 2'b11, 1'b0); a2 = accept_cyc;
    send(4'h5, 4'h6, 2'b11, 1'b1);
    send(4'h7, 4'h8, 2'b11, 1'b1); a4 = accept_cyc;
    chk("stream_gap1", a2 - a1, PREFETCH ? 2 : 3);
    chk("stream_total", a4 - a1, PREFETCH ? 6 : 9);
    repeat (6) @(negedge clk);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_idle", m_valid_o, 0);
    @(posedge clk); #1;

    // Reset mid-packet
    send(4'h9, 4'hC, 2'b11, 1'b1);
    expect_out("mid0", 1'b1, 4'h9, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid_o, 0);
    chk("mid_rst_data", m_data_o, 0);
    chk("mid_rst_s_ready", s_ready_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_s_ready", s_ready_o, 1);
    chk("mid_rel_valid", m_valid_o, 0);
    @(posedge clk); #1;
    send(4'hE, 4'hD, 2'b01, 1'b1);
    expect_out("fresh0", 1'b1, 4'hE, 1'b1);
    expect_out("fresh_end", 1'b0, 4'h0, 1'b0);

    repeat (2) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
